grf_scoreboard: RTL

- Tracks outstanding writes to the general register file for the 5-stage MIPS pipeline.
- Decode (D) checks here before reading the GRF. Issue marks a destination pending; W-stage write-back clears it.
- Asserts a D-stage stall when a source register has an unfinished write.
- The write-back bypass lets a consumer proceed in the same cycle W writes the register, matching the GRF's internal forwarding.

---
 rtl/grf_scoreboard_pkg.sv | 15 +
 rtl/grf_scoreboard_counter.sv | 53 +++++
 rtl/grf_scoreboard.sv | 99 +++++++++
 3 files changed

// File: rtl/grf_scoreboard_pkg.sv
// Shared constants for the GRF write scoreboard.
package grf_scoreboard_pkg;

  localparam int unsigned GRF_NREG = 32;
  localparam int unsigned GRF_AW   = 5;
  localparam int unsigned GRF_CW   = 2;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned CMAX     = (1 << GRF_CW) - 1;

  // Saturation limit for a counter of the given width.
  function automatic int unsigned cnt_max(input int unsigned cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/grf_scoreboard_counter.sv
// sb_counter: one register's pending-writer counter.
//   clk, reset (async active-low)
//   inc, dec_w, dec_k : per-edge events, netted as one signed sum
//   cnt               : current count of in-flight writers
//   err               : sticky underflow/overflow flag
module sb_counter
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned CW = GRF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec_w,
  input  logic          dec_k,
  output logic [CW-1:0] cnt,
  output logic          err
);

  localparam int LIMIT = int'(cnt_max(CW));

  int            sum;
  logic [CW-1:0] cnt_nxt;
  logic          bad;

  // Underflow clamps to zero; overflow holds the current (saturated) value.
  always_comb begin
    sum     = int'(cnt) + int'(inc) - int'(dec_w) - int'(dec_k);
    cnt_nxt = cnt;
    bad     = 1'b0;
    if (sum < 0) begin
      cnt_nxt = '0;
      bad     = 1'b1;
    end else if (sum > LIMIT) begin
      bad     = 1'b1;
    end else begin
      cnt_nxt = sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: tracks outstanding GRF writes and raises the D-stage stall.
//   clk, reset (async active-low)
//   issue_valid/issue_we/issue_rd : instruction leaving D, marks rd pending
//   wb_valid/wb_rd                : W-stage write-back, clears one writer
//   kill_valid/kill_rd            : squashed in-flight writer, clears one writer
//   rs_addr/rs_use, rt_addr/rt_use: D-stage sources
//   stall    : combinational RAW stall (write-back bypass honoured)
//   pending  : bit i set while register i has writers in flight
//   inflight : number of registers with writers in flight
//   err      : sticky counter underflow/overflow
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = GRF_NREG,
  parameter int unsigned AW   = GRF_AW,
  parameter int unsigned CW   = GRF_CW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            kill_valid,
  input  logic [AW-1:0]   kill_rd,
  input  logic [AW-1:0]   rs_addr,
  input  logic            rs_use,
  input  logic [AW-1:0]   rt_addr,
  input  logic            rt_use,
  output logic            stall,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     inflight,
  output logic            err
);

  logic [CW-1:0]   cnt [NREG];
  logic [NREG-1:1] cerr;
  logic            issue_fire;

  assign cnt[ZERO_REG] = '0;
  assign issue_fire    = issue_valid && issue_we && !stall;

  // Register 0 gets no counter, so events aimed at it vanish here.
  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    logic inc_g;
    logic dec_w_g;
    logic dec_k_g;

    assign inc_g   = issue_fire && (issue_rd == AW'(g));
    assign dec_w_g = wb_valid   && (wb_rd    == AW'(g));
    assign dec_k_g = kill_valid && (kill_rd  == AW'(g));

    sb_counter #(
      .CW (CW)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_g),
      .dec_w (dec_w_g),
      .dec_k (dec_k_g),
      .cnt   (cnt[g]),
      .err   (cerr[g])
    );
  end

  logic [CW-1:0] rs_cnt;
  logic [CW-1:0] rt_cnt;
  logic          rs_byp;
  logic          rt_byp;
  logic          rs_hz;
  logic          rt_hz;

  // A source whose last writer lands this cycle is forwarded by the GRF,
  // unless that same register is also being squashed.
  always_comb begin
    rs_cnt = cnt[rs_addr];
    rt_cnt = cnt[rt_addr];
    rs_byp = wb_valid && (wb_rd == rs_addr) && (rs_cnt == CW'(1))
             && !(kill_valid && (kill_rd == rs_addr));
    rt_byp = wb_valid && (wb_rd == rt_addr) && (rt_cnt == CW'(1))
             && !(kill_valid && (kill_rd == rt_addr));
    rs_hz  = (rs_addr != AW'(ZERO_REG)) && (rs_cnt != '0) && !rs_byp;
    rt_hz  = (rt_addr != AW'(ZERO_REG)) && (rt_cnt != '0) && !rt_byp;
    stall  = (rs_use && rs_hz) || (rt_use && rt_hz);
  end

  always_comb begin
    pending  = '0;
    inflight = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pending[i] = (cnt[i] != '0);
      inflight   = inflight + (AW+1)'(pending[i]);
    end
  end

  assign err = |cerr;

endmodule
